// File: rtl/aes_enc_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round sequencer and its surroundings.
// master is the sequencer side; slave is the block-source / key-unit / datapath side.
interface aes_enc_ctrl_if #(
  parameter int RND_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             key_valid;
  logic             key_ack;
  logic [RND_W-1:0] rnd_idx;
  logic             en;
  logic             full_enc;
  logic             zero_rnd;
  logic             final_rnd;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    input  in_valid, abort, key_valid, out_ready,
    output in_ready, key_ack, rnd_idx, en, full_enc, zero_rnd, final_rnd,
           out_valid, busy
  );

  modport slave (
    output in_valid, abort, key_valid, out_ready,
    input  in_ready, key_ack, rnd_idx, en, full_enc, zero_rnd, final_rnd,
           out_valid, busy
  );
endinterface

// File: rtl/aes_enc_ctrl.sv
// Round sequencer for the iterative AES-128 encryption datapath: drives en/full_enc/zero_rnd/
// final_rnd per round, fetches round keys by index and hands off the ciphertext with valid/ready.
module aes_enc_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_LAT  = 3,
  parameter int RND_W      = 4
) (
  input logic            clk,
  input logic            nrst,
  aes_enc_ctrl_if.master bus
);

  localparam int                CYC_W    = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [RND_W-1:0]  LAST_RND = RND_W'(NUM_ROUNDS);
  localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(ROUND_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    R0,
    KWAIT,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [RND_W-1:0] rnd_idx_q, rnd_idx_d;
  logic             en_q, en_d;
  logic             full_enc_q, full_enc_d;
  logic             zero_rnd_q, zero_rnd_d;
  logic             final_rnd_q, final_rnd_d;
  logic             key_ack_q, key_ack_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             cyc_last;
  logic [RND_W-1:0] rnd_nxt;
  logic             advance;

  assign cyc_last = (cyc_q == LAST_CYC);
  assign rnd_nxt  = rnd_idx_q + RND_W'(1);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    rnd_idx_d   = rnd_idx_q;
    en_d        = 1'b0;
    full_enc_d  = 1'b0;
    zero_rnd_d  = 1'b0;
    final_rnd_d = 1'b0;
    key_ack_d   = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.in_valid) begin
          state_d    = R0;
          cyc_d      = '0;
          rnd_idx_d  = '0;
          en_d       = 1'b1;
          full_enc_d = 1'b1;
          zero_rnd_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      R0: begin
        if (!cyc_last) begin
          cyc_d      = cyc_q + CYC_W'(1);
          en_d       = 1'b1;
          full_enc_d = 1'b1;
          zero_rnd_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end

      KWAIT: begin
        if (bus.key_valid) begin
          state_d     = RUN;
          cyc_d       = '0;
          en_d        = 1'b1;
          key_ack_d   = 1'b1;
          final_rnd_d = (rnd_idx_q == LAST_RND);
        end
      end

      RUN: begin
        if (!cyc_last) begin
          cyc_d       = cyc_q + CYC_W'(1);
          en_d        = 1'b1;
          final_rnd_d = (rnd_idx_q == LAST_RND);
        end else if (rnd_idx_q == LAST_RND) begin
          state_d     = DONE;
          cyc_d       = '0;
          out_valid_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d   = IDLE;
          rnd_idx_d = '0;
          busy_d    = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        cyc_d     = '0;
        rnd_idx_d = '0;
        busy_d    = 1'b0;
      end
    endcase

    // Key for the next round is sampled in the last cycle of the current one so a ready key costs no stall.
    if (advance) begin
      rnd_idx_d = rnd_nxt;
      cyc_d     = '0;
      if (bus.key_valid) begin
        state_d     = RUN;
        en_d        = 1'b1;
        key_ack_d   = 1'b1;
        final_rnd_d = (rnd_nxt == LAST_RND);
      end else begin
        state_d = KWAIT;
      end
    end

    if (bus.abort) begin
      state_d     = IDLE;
      cyc_d       = '0;
      rnd_idx_d   = '0;
      en_d        = 1'b0;
      full_enc_d  = 1'b0;
      zero_rnd_d  = 1'b0;
      final_rnd_d = 1'b0;
      key_ack_d   = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      rnd_idx_q   <= '0;
      en_q        <= 1'b0;
      full_enc_q  <= 1'b0;
      zero_rnd_q  <= 1'b0;
      final_rnd_q <= 1'b0;
      key_ack_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      rnd_idx_q   <= rnd_idx_d;
      en_q        <= en_d;
      full_enc_q  <= full_enc_d;
      zero_rnd_q  <= zero_rnd_d;
      final_rnd_q <= final_rnd_d;
      key_ack_q   <= key_ack_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.key_ack   = key_ack_q;
  assign bus.rnd_idx   = rnd_idx_q;
  assign bus.en        = en_q;
  assign bus.full_enc  = full_enc_q;
  assign bus.zero_rnd  = zero_rnd_q;
  assign bus.final_rnd = final_rnd_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Bench for aes_enc_ctrl: two instances (10 rounds x 3 cycles, 2 rounds x 1 cycle) share one stimulus
// stream and are checked every cycle against an en-cycle-count model plus hand-computed timings.
module tb_aes_enc_ctrl;

  logic clk = 1'b0;
  logic nrst;
  logic in_valid, key_valid, out_ready, abort;

  aes_enc_ctrl_if #(.RND_W(4)) if0 ();
  aes_enc_ctrl_if #(.RND_W(4)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.key_valid = key_valid;
  assign if0.out_ready = out_ready;
  assign if0.abort     = abort;
  assign if1.in_valid  = in_valid;
  assign if1.key_valid = key_valid;
  assign if1.out_ready = out_ready;
  assign if1.abort     = abort;

  aes_enc_ctrl #(.NUM_ROUNDS(10), .ROUND_LAT(3), .RND_W(4)) dut0 (.clk(clk), .nrst(nrst), .bus(if0));
  aes_enc_ctrl #(.NUM_ROUNDS(2),  .ROUND_LAT(1), .RND_W(4)) dut1 (.clk(clk), .nrst(nrst), .bus(if1));

  always #5 clk = ~clk;

  // Model: phase 0 idle / 1 active / 2 done; k = en cycles already spent on the block.
  int m_phase [2];
  int m_k     [2];
  bit m_stall [2];
  bit acc_pending [2];
  int rel [2];

  int en_cnt [2], ack_cnt [2], ack_sum [2], ov_first [2], ov_cnt [2];
  int full_first [2], full_last [2], fin_first [2], fin_last [2];

  int checks = 0;
  int passed = 0;

  function automatic int nr(input int i);
    return (i == 0) ? 10 : 2;
  endfunction

  function automatic int rl(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // {in_ready, key_ack, rnd_idx[3:0], en, full_enc, zero_rnd, final_rnd, out_valid, busy}
  function automatic logic [11:0] dutVec(input int i);
    if (i == 0)
      return {if0.in_ready, if0.key_ack, if0.rnd_idx, if0.en, if0.full_enc, if0.zero_rnd,
              if0.final_rnd, if0.out_valid, if0.busy};
    return {if1.in_ready, if1.key_ack, if1.rnd_idx, if1.en, if1.full_enc, if1.zero_rnd,
            if1.final_rnd, if1.out_valid, if1.busy};
  endfunction

  function automatic logic [11:0] expVec(input int i);
    logic [11:0] v;
    int r;
    v = '0;
    r = m_k[i] / rl(i);
    case (m_phase[i])
      0: v[11] = 1'b1;
      1: begin
        v[0]   = 1'b1;
        v[9:6] = 4'(r);
        if (!m_stall[i]) begin
          v[5]  = 1'b1;
          v[4]  = (r == 0);
          v[3]  = (r == 0);
          v[2]  = (r == nr(i));
          v[10] = (m_k[i] >= rl(i)) && (m_k[i] % rl(i) == 0);
        end
      end
      default: begin
        v[0]   = 1'b1;
        v[1]   = 1'b1;
        v[9:6] = 4'(nr(i));
      end
    endcase
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_k[i] = 0;
      m_stall[i] = 1'b0;
      acc_pending[i] = 1'b0;
    end
  endtask

  // Advances the model across the coming rising edge using the inputs just driven.
  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (abort) begin
        m_phase[i] = 0;
        m_k[i] = 0;
        m_stall[i] = 1'b0;
      end else if (m_phase[i] == 0) begin
        if (in_valid) begin
          m_phase[i] = 1;
          m_k[i] = 0;
          m_stall[i] = 1'b0;
          acc_pending[i] = 1'b1;
          rel[i] = 0;
        end
      end else if (m_phase[i] == 1) begin
        if (m_stall[i]) begin
          if (key_valid) m_stall[i] = 1'b0;
        end else begin
          m_k[i]++;
          if (m_k[i] == (nr(i) + 1) * rl(i)) m_phase[i] = 2;
          else if (m_k[i] % rl(i) == 0) m_stall[i] = !key_valid;
        end
      end else if (out_ready) begin
        m_phase[i] = 0;
      end
    end
  endtask

  task automatic checkOutput();
    logic [11:0] v;
    for (int i = 0; i < 2; i++) begin
      v = dutVec(i);
      checkEq($sformatf("cycle_outputs_dut%0d", i), {20'd0, v}, {20'd0, expVec(i)});
      if (acc_pending[i]) begin
        acc_pending[i] = 1'b0;
        en_cnt[i] = 0; ack_cnt[i] = 0; ack_sum[i] = 0; ov_first[i] = -1; ov_cnt[i] = 0;
        full_first[i] = -1; full_last[i] = -1; fin_first[i] = -1; fin_last[i] = -1;
      end
      rel[i]++;
      if (v[5]) en_cnt[i]++;
      if (v[10]) begin
        ack_cnt[i]++;
        ack_sum[i] += int'(v[9:6]);
      end
      if (v[4]) begin
        if (full_first[i] < 0) full_first[i] = rel[i];
        full_last[i] = rel[i];
      end
      if (v[2]) begin
        if (fin_first[i] < 0) fin_first[i] = rel[i];
        fin_last[i] = rel[i];
      end
      if (v[1]) begin
        if (ov_first[i] < 0) ov_first[i] = rel[i];
        ov_cnt[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic kv, input logic ordy, input logic ab);
    @(negedge clk);
    checkOutput();
    in_valid  = iv;
    key_valid = kv;
    out_ready = ordy;
    abort     = ab;
    modelStep();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rel[i] = 0; en_cnt[i] = 0; ack_cnt[i] = 0; ack_sum[i] = 0; ov_first[i] = -1; ov_cnt[i] = 0;
      full_first[i] = -1; full_last[i] = -1; fin_first[i] = -1; fin_last[i] = -1;
    end
    nrst = 1'b0;
    in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkEq("reset_outputs_dut0", {20'd0, dutVec(0)}, 32'h800);
    checkEq("reset_outputs_dut1", {20'd0, dutVec(1)}, 32'h800);
    nrst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Nominal block, key always ready.
    for (int c = 0; c < 40; c++) applyStimulus(c == 0, 1'b1, 1'b1, 1'b0);
    checkEq("s1_out_valid_cycle", ov_first[0], 34);
    checkEq("s1_en_cycles", en_cnt[0], 33);
    checkEq("s1_key_ack_count", ack_cnt[0], 10);
    checkEq("s1_key_ack_idx_sum", ack_sum[0], 55);
    checkEq("s1_full_enc_first", full_first[0], 1);
    checkEq("s1_full_enc_last", full_last[0], 3);
    checkEq("s1_final_first", fin_first[0], 31);
    checkEq("s1_final_last", fin_last[0], 33);
    checkEq("s6_out_valid_cycle", ov_first[1], 4);
    checkEq("s6_en_cycles", en_cnt[1], 3);
    checkEq("s6_final_first", fin_first[1], 3);
    checkEq("s6_final_last", fin_last[1], 3);
    checkEq("s6_key_ack_count", ack_cnt[1], 2);

    // Key unit stalls five cycles at the start of round 4.
    for (int c = 0; c < 45; c++) applyStimulus(c == 0, !(c >= 12 && c <= 16), 1'b1, 1'b0);
    checkEq("s2_out_valid_cycle", ov_first[0], 39);
    checkEq("s2_en_cycles", en_cnt[0], 33);
    checkEq("s2_key_ack_count", ack_cnt[0], 10);

    // Downstream backpressure with a new block already waiting.
    for (int c = 0; c < 42; c++) applyStimulus((c == 0) || (c >= 35), 1'b1, c >= 41, 1'b0);
    checkEq("s3_out_valid_cycle", ov_first[0], 34);
    checkEq("s3_out_valid_hold", ov_cnt[0], 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkEq("s3_in_ready_after_handoff", {31'd0, if0.in_ready}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkEq("s3_next_block_full_enc", {31'd0, if0.full_enc}, 32'd1);
    for (int c = 44; c < 80; c++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkEq("s3_next_block_out_valid", ov_first[0], 34);

    // Abort in the second cycle of round 6, then a clean block.
    for (int c = 0; c < 22; c++) applyStimulus(c == 0, 1'b1, 1'b1, c == 20);
    checkEq("s4_after_abort", {20'd0, dutVec(0)}, 32'h800);
    for (int c = 0; c < 40; c++) applyStimulus(c == 0, 1'b1, 1'b1, 1'b0);
    checkEq("s4_fresh_out_valid_cycle", ov_first[0], 34);
    checkEq("s4_fresh_en_cycles", en_cnt[0], 33);

    // Asynchronous reset in round 9.
    for (int c = 0; c < 30; c++) applyStimulus(c == 0, 1'b1, 1'b1, 1'b0);
    #1 nrst = 1'b0;
    #1;
    checkEq("s5_async_reset_dut0", {20'd0, dutVec(0)}, 32'h800);
    checkEq("s5_async_reset_dut1", {20'd0, dutVec(1)}, 32'h800);
    modelReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    nrst = 1'b1;
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkEq("s5_no_out_valid", ov_first[0], -1);

    // Random traffic on all inputs.
    for (int c = 0; c < 3000; c++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
